ac97_codec_link: RTL and testbench
==================================

AC97_CODEC_LINK -- requirements
Module: ac97_codec_link

Interface
REQ-001 Parameter: VENDOR_ID1, default 16'h4144, value returned for reads of register 0x7C.
REQ-002 Parameter: VENDOR_ID2, default 16'h5370, value returned for reads of register 0x7E.
REQ-003 clk  in  1  AC-link bit clock; every input is sampled and every output updates on its rising edge. Single clock.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 ac97_sync  in  1  frame sync driven by the controller.
REQ-006 ac97_sdata_out  in  1  serial data from the controller to this block.
REQ-007 ac97_sdata_in  out  1  serial data from this block to the controller.
REQ-008 codec_ready  in  1  value placed in transmitted tag bit 15.
REQ-009 pcm_in_left, pcm_in_right  in  20 each  capture sample to send.
REQ-010 pcm_in_strobe  in  1  one-cycle pulse; latches pcm_in_left/right.
REQ-011 pcm_out_left, pcm_out_right  out  20 each  playback sample received in slots 3 and 4.
REQ-012 pcm_out_strobe  out  1  one-cycle pulse; pcm_out_left/right updated this cycle.
REQ-013 reg_wr_strobe / reg_wr_addr / reg_wr_data  out  1 / 7 / 16  reports each accepted register write.
REQ-014 frame_strobe  out  1  pulse when a complete 256-bit frame is received.
REQ-015 frame_err  out  1  pulse when a frame is aborted.

Function
REQ-016 FSM states: IDLE, RX. A sync rise is ac97_sync sampled 1 with the previous sample 0. A sync rise in either state goes to RX with bitcnt=0. Call that cycle S.
REQ-017 Receive: the ac97_sdata_out sample at cycle S+1+k is frame bit k (k=0..255, bit 0 = tag MSB). It is shifted into a 256-bit buffer.
REQ-018 After bit 255 is sampled: go to IDLE and pulse frame_strobe for 1 cycle. Decode the frame in that same cycle; all decode effects are visible 1 cycle later.
REQ-019 Sync rise while in RX with k<255: discard the partial frame, pulse frame_err, restart RX at bitcnt=0.
REQ-020 Decode is skipped when tag bit 15 is 0; frame_strobe still pulses.
REQ-021 Command field decoding:
- Slot1: bit19 = read, bits18:12 = addr.
- Slot2: bits19:4 = data.
- Slot n valid = tag bit (15-n).
REQ-022 Write: accepted when slot1 valid, slot2 valid and read=0.
- Registers are 64 x 16, indexed by addr[6:1]; addr[0] is ignored.
- Pulse reg_wr_strobe with addr and data on the outputs.
REQ-023 Writes to 0x7C and 0x7E are ignored (no strobe).
REQ-024 A write to 0x00 restores every register to its reset default.
REQ-025 Read: accepted when slot1 valid and read=1.
- Sets the read-pending flag and latches addr and the register data (VENDOR_ID for 0x7C and 0x7E).
- A later read before transmission overwrites the latched values.
REQ-026 Playback: slot3 valid loads pcm_out_left from slot3; slot4 valid loads pcm_out_right from slot4. pcm_out_strobe pulses if either slot loaded.
REQ-027 Capture: pcm_in_strobe latches both samples and sets the capture-pending flag. A second strobe before transmission overwrites the latched samples.
REQ-028 Transmit snapshot at every sync rise cycle S:
- tag15 = codec_ready; tag14 = tag13 = read-pending; tag12 = tag11 = capture-pending; other tag bits 0.
- slot1 = {0, addr, 12'h000}; slot2 = {data, 4'h0}; slot3 = left; slot4 = right; other slots 0.
- Invalid slots are transmitted as 0.
- Both pending flags clear at S.
- A pcm_in_strobe in cycle S sets capture-pending for the next frame (set wins over clear).
REQ-029 ac97_sdata_in is registered. It carries snapshot bit k from edge S+k until edge S+k+1, k=0..255.
REQ-030 In IDLE with no sync rise, ac97_sdata_in holds 0 once bit 255 has been sent.
REQ-031 Latency: a read received in frame N is answered in frame N+2, because the snapshot for frame N+1 is taken in the cycle that frame N completes.

Reset
REQ-032 While rst=1:
- FSM=IDLE, bitcnt=0, both pending flags=0.
- ac97_sdata_in=0; every strobe output=0; pcm_out_left/right=0; reg_wr_addr=0; reg_wr_data=0.
- All registers=16'h0000 except 0x02, 0x18 and 0x1C = 16'h8000 (muted).
REQ-033 A reset asserted mid-frame abandons the frame with no strobes. Reception restarts only on a sync rise after rst deasserts.

Verification
REQ-034 Write 0x02 <- 16'h1234, then read 0x02 -> reg_wr_strobe with (0x02, 16'h1234); two frames later tag=16'hE000, slot1=20'h02000, slot2=20'h12340.
REQ-035 Read 0x7E after writing 0x7E <- 16'h0000 -> no reg_wr_strobe; reply slot2=20'h53700.
REQ-036 Frame with tag 16'h9800, slot3=20'hABCDE, slot4=20'h12345 -> one pcm_out_strobe, outputs equal 20'hABCDE / 20'h12345; tag 16'h1800 -> no strobe.
REQ-037 pcm_in_strobe with 20'h11111 / 20'h22222 -> next frame tag bits 12 and 11 set, slots 3 and 4 carry those values, following frame has them cleared.
REQ-038 Sync rise after 100 bits -> frame_err pulse, no decode; next full frame decodes normally; rst mid-frame -> no strobes, 0x18 reads back 16'h8000.

Source files
------------

// File: rtl/ac97_codec_link.sv
// Codec side of an AC-link: receives 256-bit frames from the controller, decodes the
// register and playback slots, and shifts out the reply/capture frame.
module ac97_codec_link #(
    parameter logic [15:0] VENDOR_ID1 = 16'h4144,
    parameter logic [15:0] VENDOR_ID2 = 16'h5370
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ac97_sync,
    input  logic        ac97_sdata_out,
    output logic        ac97_sdata_in,
    input  logic        codec_ready,
    input  logic [19:0] pcm_in_left,
    input  logic [19:0] pcm_in_right,
    input  logic        pcm_in_strobe,
    output logic [19:0] pcm_out_left,
    output logic [19:0] pcm_out_right,
    output logic        pcm_out_strobe,
    output logic        reg_wr_strobe,
    output logic [6:0]  reg_wr_addr,
    output logic [15:0] reg_wr_data,
    output logic        frame_strobe,
    output logic        frame_err
);

    localparam int unsigned FRAME_W = 256;
    localparam int unsigned NREGS   = 64;

    typedef enum logic {IDLE, RX} state_t;

    state_t              state_q;
    logic [7:0]          bitcnt_q;
    logic                sync_q;
    logic [FRAME_W-1:0]  rx_buf_q;
    logic [FRAME_W-1:0]  tx_sr_q;
    logic                sdata_in_q;
    logic                rd_pend_q;
    logic                cap_pend_q;
    logic [6:0]          rd_addr_q;
    logic [15:0]         rd_data_q;
    logic [19:0]         cap_l_q;
    logic [19:0]         cap_r_q;
    logic [19:0]         pcm_l_q;
    logic [19:0]         pcm_r_q;
    logic [15:0]         regs_q [NREGS];
    logic                pcm_strobe_q;
    logic                wr_strobe_q;
    logic                frame_strobe_q;
    logic                frame_err_q;
    logic [6:0]          wr_addr_q;
    logic [15:0]         wr_data_q;

    logic                sync_rise;
    logic [15:0]         tag;
    logic [19:0]         slot1;
    logic [19:0]         slot2;
    logic [19:0]         slot3;
    logic [19:0]         slot4;
    logic                dec_en;
    logic                dec_read;
    logic [6:0]          dec_addr;
    logic [15:0]         dec_data;
    logic                wr_ok;
    logic                rd_ok;
    logic [15:0]         rd_data_d;
    logic [FRAME_W-1:0]  tx_frame_d;
    logic                unused_rx;

    function automatic logic [15:0] reg_default(input logic [5:0] idx);
        case (idx)
            6'd1, 6'd12, 6'd14: return 16'h8000;
            default:            return 16'h0000;
        endcase
    endfunction

    assign sync_rise = ac97_sync & ~sync_q;

    // The completed frame sits in rx_buf_q during the cycle frame_strobe is high.
    assign tag      = rx_buf_q[255:240];
    assign slot1    = rx_buf_q[239:220];
    assign slot2    = rx_buf_q[219:200];
    assign slot3    = rx_buf_q[199:180];
    assign slot4    = rx_buf_q[179:160];
    assign unused_rx = ^rx_buf_q;

    assign dec_en   = frame_strobe_q & tag[15];
    assign dec_read = slot1[19];
    assign dec_addr = slot1[18:12];
    assign dec_data = slot2[19:4];
    assign wr_ok    = dec_en & tag[14] & tag[13] & ~dec_read
                      & (dec_addr != 7'h7C) & (dec_addr != 7'h7E);
    assign rd_ok    = dec_en & tag[14] & dec_read;

    always_comb begin
        rd_data_d = regs_q[dec_addr[6:1]];
        if (dec_addr == 7'h7C) begin
            rd_data_d = VENDOR_ID1;
        end else if (dec_addr == 7'h7E) begin
            rd_data_d = VENDOR_ID2;
        end
    end

    assign tx_frame_d = {codec_ready, rd_pend_q, rd_pend_q, cap_pend_q, cap_pend_q, 11'h000,
                         rd_pend_q  ? {1'b0, rd_addr_q, 12'h000} : 20'h00000,
                         rd_pend_q  ? {rd_data_q, 4'h0}          : 20'h00000,
                         cap_pend_q ? cap_l_q                    : 20'h00000,
                         cap_pend_q ? cap_r_q                    : 20'h00000,
                         160'h0};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            bitcnt_q       <= 8'd0;
            sync_q         <= ac97_sync;
            rx_buf_q       <= '0;
            tx_sr_q        <= '0;
            sdata_in_q     <= 1'b0;
            rd_pend_q      <= 1'b0;
            cap_pend_q     <= 1'b0;
            rd_addr_q      <= 7'h00;
            rd_data_q      <= 16'h0000;
            cap_l_q        <= 20'h00000;
            cap_r_q        <= 20'h00000;
            pcm_l_q        <= 20'h00000;
            pcm_r_q        <= 20'h00000;
            pcm_strobe_q   <= 1'b0;
            wr_strobe_q    <= 1'b0;
            frame_strobe_q <= 1'b0;
            frame_err_q    <= 1'b0;
            wr_addr_q      <= 7'h00;
            wr_data_q      <= 16'h0000;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= reg_default(6'(i));
            end
        end else begin
            sync_q         <= ac97_sync;
            frame_strobe_q <= 1'b0;
            frame_err_q    <= 1'b0;
            wr_strobe_q    <= 1'b0;
            pcm_strobe_q   <= 1'b0;

            if (state_q == RX) begin
                rx_buf_q <= {rx_buf_q[FRAME_W-2:0], ac97_sdata_out};
            end

            // A sync rise coinciding with bit 255 both completes and restarts.
            case (state_q)
                IDLE: begin
                    if (sync_rise) begin
                        state_q  <= RX;
                        bitcnt_q <= 8'd0;
                    end
                end
                RX: begin
                    if (bitcnt_q == 8'd255) begin
                        frame_strobe_q <= 1'b1;
                        state_q        <= sync_rise ? RX : IDLE;
                        bitcnt_q       <= 8'd0;
                    end else if (sync_rise) begin
                        frame_err_q <= 1'b1;
                        bitcnt_q    <= 8'd0;
                    end else begin
                        bitcnt_q <= bitcnt_q + 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (sync_rise) begin
                sdata_in_q <= tx_frame_d[FRAME_W-1];
                tx_sr_q    <= {tx_frame_d[FRAME_W-2:0], 1'b0};
            end else begin
                sdata_in_q <= tx_sr_q[FRAME_W-1];
                tx_sr_q    <= {tx_sr_q[FRAME_W-2:0], 1'b0};
            end

            if (pcm_in_strobe) begin
                cap_pend_q <= 1'b1;
                cap_l_q    <= pcm_in_left;
                cap_r_q    <= pcm_in_right;
            end else if (sync_rise) begin
                cap_pend_q <= 1'b0;
            end

            if (rd_ok) begin
                rd_pend_q <= 1'b1;
                rd_addr_q <= dec_addr;
                rd_data_q <= rd_data_d;
            end else if (sync_rise) begin
                rd_pend_q <= 1'b0;
            end

            if (wr_ok) begin
                wr_strobe_q <= 1'b1;
                wr_addr_q   <= dec_addr;
                wr_data_q   <= dec_data;
                if (dec_addr == 7'h00) begin
                    for (int i = 0; i < NREGS; i++) begin
                        regs_q[i] <= reg_default(6'(i));
                    end
                end else begin
                    regs_q[dec_addr[6:1]] <= dec_data;
                end
            end

            if (dec_en & (tag[12] | tag[11])) begin
                pcm_strobe_q <= 1'b1;
                if (tag[12]) pcm_l_q <= slot3;
                if (tag[11]) pcm_r_q <= slot4;
            end
        end
    end

    assign ac97_sdata_in  = sdata_in_q;
    assign pcm_out_left   = pcm_l_q;
    assign pcm_out_right  = pcm_r_q;
    assign pcm_out_strobe = pcm_strobe_q;
    assign reg_wr_strobe  = wr_strobe_q;
    assign reg_wr_addr    = wr_addr_q;
    assign reg_wr_data    = wr_data_q;
    assign frame_strobe   = frame_strobe_q;
    assign frame_err      = frame_err_q;

endmodule

// File: tb/tb_ac97_codec_link.sv
// Scoreboard bench for ac97_codec_link: drives back-to-back frames, predicts the
// register/playback strobes and the transmitted frames, and compares on the fly.
module tb_ac97_codec_link;

    logic        clk = 1'b0;
    logic        rst;
    logic        ac97_sync;
    logic        ac97_sdata_out;
    logic        ac97_sdata_in;
    logic        codec_ready;
    logic [19:0] pcm_in_left;
    logic [19:0] pcm_in_right;
    logic        pcm_in_strobe;
    logic [19:0] pcm_out_left;
    logic [19:0] pcm_out_right;
    logic        pcm_out_strobe;
    logic        reg_wr_strobe;
    logic [6:0]  reg_wr_addr;
    logic [15:0] reg_wr_data;
    logic        frame_strobe;
    logic        frame_err;

    always #5 clk = ~clk;

    ac97_codec_link dut (
        .clk            (clk),
        .rst            (rst),
        .ac97_sync      (ac97_sync),
        .ac97_sdata_out (ac97_sdata_out),
        .ac97_sdata_in  (ac97_sdata_in),
        .codec_ready    (codec_ready),
        .pcm_in_left    (pcm_in_left),
        .pcm_in_right   (pcm_in_right),
        .pcm_in_strobe  (pcm_in_strobe),
        .pcm_out_left   (pcm_out_left),
        .pcm_out_right  (pcm_out_right),
        .pcm_out_strobe (pcm_out_strobe),
        .reg_wr_strobe  (reg_wr_strobe),
        .reg_wr_addr    (reg_wr_addr),
        .reg_wr_data    (reg_wr_data),
        .frame_strobe   (frame_strobe),
        .frame_err      (frame_err)
    );

    int errors = 0;
    int checks = 0;

    logic [255:0] tx_q  [$];
    logic [22:0]  wr_q  [$];
    logic [39:0]  pcm_q [$];

    logic [15:0]  m_regs [64];
    logic         m_rp, m_cp;
    logic [6:0]   m_ra;
    logic [15:0]  m_rd;
    logic [19:0]  m_cl, m_cr, m_pl, m_pr;
    logic [255:0] prev_f;
    logic         prev_valid;
    logic         last_bit;
    int           exp_fs = 0;
    int           exp_fe = 0;
    int           fs_cnt = 0;
    int           fe_cnt = 0;

    int           mon_cnt = 256;
    logic         mon_prev = 1'b0;
    logic [255:0] mon_buf;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [255:0] mk(input logic [15:0] t, input logic [19:0] s1,
                                        input logic [19:0] s2, input logic [19:0] s3,
                                        input logic [19:0] s4);
        return {t, s1, s2, s3, s4, 160'h0};
    endfunction

    function automatic logic [255:0] wr_f(input logic [6:0] a, input logic [15:0] d);
        return mk(16'hE000, {1'b0, a, 12'h000}, {d, 4'h0}, 20'h0, 20'h0);
    endfunction

    function automatic logic [255:0] rd_f(input logic [6:0] a);
        return mk(16'hC000, {1'b1, a, 12'h000}, 20'h0, 20'h0, 20'h0);
    endfunction

    function automatic logic [15:0] m_default(input int i);
        return (i == 1 || i == 12 || i == 14) ? 16'h8000 : 16'h0000;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_regs[i] = m_default(i);
        m_rp = 1'b0; m_cp = 1'b0; m_ra = 7'h0; m_rd = 16'h0;
        m_cl = 20'h0; m_cr = 20'h0; m_pl = 20'h0; m_pr = 20'h0;
        prev_valid = 1'b0;
    endtask

    function automatic logic [255:0] snap_model();
        return {codec_ready, m_rp, m_rp, m_cp, m_cp, 11'h000,
                m_rp ? {1'b0, m_ra, 12'h000} : 20'h0,
                m_rp ? {m_rd, 4'h0} : 20'h0,
                m_cp ? m_cl : 20'h0,
                m_cp ? m_cr : 20'h0,
                160'h0};
    endfunction

    task automatic apply(input logic [255:0] f);
        logic [15:0] t;
        logic [19:0] s1, s2, s3, s4;
        logic [6:0]  a;
        t = f[255:240]; s1 = f[239:220]; s2 = f[219:200]; s3 = f[199:180]; s4 = f[179:160];
        a = s1[18:12];
        if (t[15]) begin
            if (t[14] && t[13] && !s1[19] && a != 7'h7C && a != 7'h7E) begin
                wr_q.push_back({a, s2[19:4]});
                if (a == 7'h00) begin
                    for (int i = 0; i < 64; i++) m_regs[i] = m_default(i);
                end else begin
                    m_regs[a[6:1]] = s2[19:4];
                end
            end
            if (t[14] && s1[19]) begin
                m_rp = 1'b1;
                m_ra = a;
                m_rd = (a == 7'h7C) ? 16'h4144 : (a == 7'h7E) ? 16'h5370 : m_regs[a[6:1]];
            end
            if (t[12] || t[11]) begin
                if (t[12]) m_pl = s3;
                if (t[11]) m_pr = s4;
                pcm_q.push_back({m_pl, m_pr});
            end
        end
    endtask

    // Cycle c=0 is the sync-rise edge; c>=1 carries frame bit c-1.
    task automatic drive_frame(input logic [255:0] f, input int nbits, input int cap_at,
                               input logic [19:0] cl, input logic [19:0] cr);
        int idx;
        for (int c = 0; c <= nbits; c++) begin
            @(negedge clk);
            ac97_sync = (c < 16);
            if (c == 0) begin
                ac97_sdata_out = last_bit;
            end else begin
                idx = 256 - c;
                ac97_sdata_out = f[idx];
            end
            pcm_in_strobe = (c == cap_at);
            if (c == cap_at) begin
                pcm_in_left  = cl;
                pcm_in_right = cr;
            end
        end
        last_bit = f[0];
    endtask

    task automatic send(input logic [255:0] f, input int cap_at,
                        input logic [19:0] cl, input logic [19:0] cr);
        tx_q.push_back(snap_model());
        m_rp = 1'b0; m_cp = 1'b0;
        if (prev_valid) apply(prev_f);
        if (cap_at >= 0) begin
            m_cp = 1'b1; m_cl = cl; m_cr = cr;
        end
        exp_fs++;
        drive_frame(f, 255, cap_at, cl, cr);
        prev_f = f;
        prev_valid = 1'b1;
    endtask

    task automatic send_partial(input logic [255:0] f, input int nbits);
        m_rp = 1'b0; m_cp = 1'b0;
        if (prev_valid) apply(prev_f);
        drive_frame(f, nbits, -1, 20'h0, 20'h0);
        prev_valid = 1'b0;
    endtask

    task automatic flush(input int cycles);
        if (prev_valid) apply(prev_f);
        prev_valid = 1'b0;
        @(negedge clk);
        ac97_sync = 1'b0;
        ac97_sdata_out = last_bit;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic mid_reset();
        @(negedge clk);
        rst = 1'b1;
        ac97_sync = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic compare_tx();
        logic [255:0] e;
        if (tx_q.size() == 0) begin
            check("tx_unexpected", 64'(1), 64'(0));
        end else begin
            e = tx_q.pop_front();
            check("tx_tag",   64'(mon_buf[255:240]), 64'(e[255:240]));
            check("tx_slot1", 64'(mon_buf[239:220]), 64'(e[239:220]));
            check("tx_slot2", 64'(mon_buf[219:200]), 64'(e[219:200]));
            check("tx_slot3", 64'(mon_buf[199:180]), 64'(e[199:180]));
            check("tx_slot4", 64'(mon_buf[179:160]), 64'(e[179:160]));
            check("tx_rest",  64'(|mon_buf[159:0]),  64'(0));
        end
    endtask

    // Output monitor, sampled 2 time units after each rising edge.
    always @(posedge clk) begin
        logic [22:0] ew;
        logic [39:0] ep;
        #2;
        if (rst) begin
            mon_cnt  = 256;
            mon_prev = ac97_sync;
            check("rst_strobes",
                  64'({frame_strobe, frame_err, reg_wr_strobe, pcm_out_strobe}), 64'(0));
        end else begin
            if (ac97_sync && !mon_prev) mon_cnt = 0;
            mon_prev = ac97_sync;
            if (mon_cnt < 256) begin
                mon_buf[255 - mon_cnt] = ac97_sdata_in;
                mon_cnt++;
                if (mon_cnt == 256) compare_tx();
            end else begin
                check("tx_idle", 64'(ac97_sdata_in), 64'(0));
            end
            if (reg_wr_strobe) begin
                if (wr_q.size() == 0) begin
                    check("wr_unexpected", 64'(1), 64'(0));
                end else begin
                    ew = wr_q.pop_front();
                    check("wr_addr", 64'(reg_wr_addr), 64'(ew[22:16]));
                    check("wr_data", 64'(reg_wr_data), 64'(ew[15:0]));
                end
            end
            if (pcm_out_strobe) begin
                if (pcm_q.size() == 0) begin
                    check("pcm_unexpected", 64'(1), 64'(0));
                end else begin
                    ep = pcm_q.pop_front();
                    check("pcm_left",  64'(pcm_out_left),  64'(ep[39:20]));
                    check("pcm_right", 64'(pcm_out_right), 64'(ep[19:0]));
                end
            end
            if (frame_strobe) fs_cnt++;
            if (frame_err) fe_cnt++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        ac97_sync = 1'b0;
        ac97_sdata_out = 1'b0;
        codec_ready = 1'b1;
        pcm_in_left = 20'h0;
        pcm_in_right = 20'h0;
        pcm_in_strobe = 1'b0;
        last_bit = 1'b0;
        prev_f = '0;
        model_reset();

        repeat (4) @(posedge clk);
        #2;
        check("rst_sdata_in", 64'(ac97_sdata_in), 64'(0));
        check("rst_pcm_left", 64'(pcm_out_left), 64'(0));
        check("rst_pcm_right", 64'(pcm_out_right), 64'(0));
        check("rst_wr_addr", 64'(reg_wr_addr), 64'(0));
        check("rst_wr_data", 64'(reg_wr_data), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        send(wr_f(7'h02, 16'h1234), -1, 20'h0, 20'h0);
        send(rd_f(7'h02), -1, 20'h0, 20'h0);
        send(mk(16'h7800, {1'b0, 7'h02, 12'h0}, {16'hDEAD, 4'h0}, 20'h55555, 20'h66666),
             -1, 20'h0, 20'h0);
        send(wr_f(7'h7E, 16'h0000), -1, 20'h0, 20'h0);
        send(rd_f(7'h7E), -1, 20'h0, 20'h0);
        send(mk(16'h9800, 20'h0, 20'h0, 20'hABCDE, 20'h12345), -1, 20'h0, 20'h0);
        send(mk(16'h1800, 20'h0, 20'h0, 20'h77777, 20'h88888), 50, 20'h11111, 20'h22222);
        send(mk(16'h8000, 20'h0, 20'h0, 20'h0, 20'h0), -1, 20'h0, 20'h0);
        send(mk(16'h8000, 20'h0, 20'h0, 20'h0, 20'h0), 0, 20'h33333, 20'h44444);
        send(mk(16'h8000, 20'h0, 20'h0, 20'h0, 20'h0), -1, 20'h0, 20'h0);

        send_partial(wr_f(7'h1C, 16'hBEEF), 100);
        exp_fe++;
        send(wr_f(7'h18, 16'h5555), -1, 20'h0, 20'h0);
        send(rd_f(7'h18), -1, 20'h0, 20'h0);
        send(wr_f(7'h00, 16'hFFFF), -1, 20'h0, 20'h0);
        send(rd_f(7'h02), -1, 20'h0, 20'h0);
        send(mk(16'h8000, 20'h0, 20'h0, 20'h0, 20'h0), -1, 20'h0, 20'h0);
        send(mk(16'h8000, 20'h0, 20'h0, 20'h0, 20'h0), -1, 20'h0, 20'h0);

        send_partial(wr_f(7'h18, 16'h0F0F), 60);
        mid_reset();
        repeat (3) @(negedge clk);
        send(rd_f(7'h18), -1, 20'h0, 20'h0);
        send(mk(16'h8000, 20'h0, 20'h0, 20'h0, 20'h0), -1, 20'h0, 20'h0);
        send(mk(16'h8000, 20'h0, 20'h0, 20'h0, 20'h0), -1, 20'h0, 20'h0);
        flush(300);

        check("frame_strobe_count", 64'(fs_cnt), 64'(exp_fs));
        check("frame_err_count", 64'(fe_cnt), 64'(exp_fe));
        check("tx_pending", 64'(tx_q.size()), 64'(0));
        check("wr_pending", 64'(wr_q.size()), 64'(0));
        check("pcm_pending", 64'(pcm_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
